// File: rtl/wb_write_arbiter.sv
// Merges two write-back lanes (R = older, I = younger) onto one register-file write port.
// Optional build macro WB_CONFLICT_STATS_EN adds a saturating 16-bit conflict counter output.
module wb_write_arbiter (
    input  logic        clk,
    input  logic        btnc_i,
    input  logic        wb_r_valid_i,
    input  logic [4:0]  wb_r_addr_i,
    input  logic [31:0] wb_r_data_i,
    input  logic        wb_i_valid_i,
    input  logic [4:0]  wb_i_addr_i,
    input  logic [31:0] wb_i_data_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        stall_o,
    output logic        pend_valid_o,
    output logic [4:0]  pend_addr_o,
    output logic [31:0] pend_data_o
`ifdef WB_CONFLICT_STATS_EN
    ,
    output logic [15:0] conflict_cnt_o
`endif
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state, state_n;
    wb_req_t     lane_r, lane_i;
    logic        r_eff, i_eff, conflict;
    logic        we_n, pend_set, pend_clr;
    logic [4:0]  waddr_n;
    logic [31:0] wdata_n;

    assign lane_r = '{valid: wb_r_valid_i, addr: wb_r_addr_i, data: wb_r_data_i};
    assign lane_i = '{valid: wb_i_valid_i, addr: wb_i_addr_i, data: wb_i_data_i};

    // Writes to r0 are architecturally discarded, so such a lane never competes.
    assign r_eff    = lane_r.valid && (lane_r.addr != 5'd0);
    assign i_eff    = lane_i.valid && (lane_i.addr != 5'd0);
    assign conflict = (state == IDLE) && r_eff && i_eff && (lane_r.addr != lane_i.addr);
    assign stall_o  = conflict && btnc_i;

    always_comb begin
        state_n  = state;
        we_n     = 1'b0;
        waddr_n  = rf_waddr_o;
        wdata_n  = rf_wdata_o;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        case (state)
            IDLE: begin
                if (conflict) begin
                    we_n     = 1'b1;
                    waddr_n  = lane_r.addr;
                    wdata_n  = lane_r.data;
                    pend_set = 1'b1;
                    state_n  = HOLD;
                end else if (i_eff) begin
                    // Also covers the same-address case: the younger value wins.
                    we_n    = 1'b1;
                    waddr_n = lane_i.addr;
                    wdata_n = lane_i.data;
                end else if (r_eff) begin
                    we_n    = 1'b1;
                    waddr_n = lane_r.addr;
                    wdata_n = lane_r.data;
                end
            end
            HOLD: begin
                we_n     = 1'b1;
                waddr_n  = pend_addr_o;
                wdata_n  = pend_data_o;
                pend_clr = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge btnc_i) begin
        if (!btnc_i) begin
            state        <= IDLE;
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= 5'd0;
            rf_wdata_o   <= 32'd0;
            pend_valid_o <= 1'b0;
            pend_addr_o  <= 5'd0;
            pend_data_o  <= 32'd0;
        end else begin
            state      <= state_n;
            rf_we_o    <= we_n;
            rf_waddr_o <= waddr_n;
            rf_wdata_o <= wdata_n;
            if (pend_set) begin
                pend_valid_o <= 1'b1;
                pend_addr_o  <= lane_i.addr;
                pend_data_o  <= lane_i.data;
            end else if (pend_clr) begin
                pend_valid_o <= 1'b0;
            end
        end
    end

`ifdef WB_CONFLICT_STATS_EN
    always_ff @(posedge clk or negedge btnc_i) begin
        if (!btnc_i)
            conflict_cnt_o <= 16'd0;
        else if (conflict && (conflict_cnt_o != 16'hFFFF))
            conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized pairs checked against
// a queue-of-writes model of the lane merge.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        btnc_i = 1'b1;
    logic        wb_r_valid_i = 1'b0;
    logic [4:0]  wb_r_addr_i = '0;
    logic [31:0] wb_r_data_i = '0;
    logic        wb_i_valid_i = 1'b0;
    logic [4:0]  wb_i_addr_i = '0;
    logic [31:0] wb_i_data_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        stall_o;
    logic        pend_valid_o;
    logic [4:0]  pend_addr_o;
    logic [31:0] pend_data_o;
`ifdef WB_CONFLICT_STATS_EN
    logic [15:0] conflict_cnt_o;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wb_write_arbiter dut (
        .clk(clk), .btnc_i(btnc_i),
        .wb_r_valid_i(wb_r_valid_i), .wb_r_addr_i(wb_r_addr_i), .wb_r_data_i(wb_r_data_i),
        .wb_i_valid_i(wb_i_valid_i), .wb_i_addr_i(wb_i_addr_i), .wb_i_data_i(wb_i_data_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .stall_o(stall_o),
        .pend_valid_o(pend_valid_o), .pend_addr_o(pend_addr_o), .pend_data_o(pend_data_o)
`ifdef WB_CONFLICT_STATS_EN
        , .conflict_cnt_o(conflict_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rv, input logic [4:0] ra, input logic [31:0] rd,
                         input logic iv, input logic [4:0] ia, input logic [31:0] id);
        wb_r_valid_i = rv; wb_r_addr_i = ra; wb_r_data_i = rd;
        wb_i_valid_i = iv; wb_i_addr_i = ia; wb_i_data_i = id;
    endtask

    task automatic test_reset();
        #1 btnc_i = 1'b0;
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
        total++; if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0) begin
            bad++; $display("FAIL rst_rf got=%b/%0d/%h exp=0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (pend_valid_o !== 1'b0 || pend_addr_o !== 5'd0 || pend_data_o !== 32'd0) begin
            bad++; $display("FAIL rst_pend got=%b/%0d/%h exp=0/0/0", pend_valid_o, pend_addr_o, pend_data_o); end
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL rst_hold_we got=%b exp=0", rf_we_o); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        btnc_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL single_stall got=%b exp=0", stall_o); end
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h1234) begin
            bad++; $display("FAIL single_wr got=%b/%0d/%h exp=1/5/1234", rf_we_o, rf_waddr_o, rf_wdata_o); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h1234) begin
            bad++; $display("FAIL idle_hold got=%b/%0d/%h exp=0/5/1234", rf_we_o, rf_waddr_o, rf_wdata_o); end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL conf_stall got=%b exp=1", stall_o); end
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'hA) begin
            bad++; $display("FAIL conf_wr_r got=%b/%0d/%h exp=1/3/a", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (pend_valid_o !== 1'b1 || pend_addr_o !== 5'd7 || pend_data_o !== 32'hB) begin
            bad++; $display("FAIL conf_pend got=%b/%0d/%h exp=1/7/b", pend_valid_o, pend_addr_o, pend_data_o); end
        @(negedge clk);
        drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd2, 32'h66);  // must be ignored in HOLD
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL hold_stall got=%b exp=0", stall_o); end
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'hB) begin
            bad++; $display("FAIL conf_wr_i got=%b/%0d/%h exp=1/7/b", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (pend_valid_o !== 1'b0 || pend_addr_o !== 5'd7 || pend_data_o !== 32'hB) begin
            bad++; $display("FAIL pend_keep got=%b/%0d/%h exp=0/7/b", pend_valid_o, pend_addr_o, pend_data_o); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL post_hold_we got=%b exp=0", rf_we_o); end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL same_stall got=%b exp=0", stall_o); end
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd9 || rf_wdata_o !== 32'h2) begin
            bad++; $display("FAIL same_wr got=%b/%0d/%h exp=1/9/2", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (pend_valid_o !== 1'b0) begin bad++; $display("FAIL same_pend got=%b exp=0", pend_valid_o); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL same_nohold got=%b exp=0", rf_we_o); end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd4, 32'h5);
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall_o); end
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd4 || rf_wdata_o !== 32'h5) begin
            bad++; $display("FAIL r0_wr got=%b/%0d/%h exp=1/4/5", rf_we_o, rf_waddr_o, rf_wdata_o); end
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        total++; if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd4) begin
            bad++; $display("FAIL r0_alone got=%b/%0d exp=0/4", rf_we_o, rf_waddr_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        pat = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, 5'd12, 32'h100 + c, 1'b1, 5'd13, 32'h200 + c);
            #1 pat[3-c] = stall_o;
            @(posedge clk); #1;
        end
        total++; if (pat !== 4'b1010) begin bad++; $display("FAIL b2b_stall got=%b exp=1010", pat); end
        // last edge was the HOLD drain of the second pair
        total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd13 || rf_wdata_o !== 32'h202) begin
            bad++; $display("FAIL b2b_wr got=%b/%0d/%h exp=1/13/202", rf_we_o, rf_waddr_o, rf_wdata_o); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_hold();
        int seen;
        @(negedge clk);
        drive(1'b1, 5'd10, 32'hCAFE, 1'b1, 5'd11, 32'hDEAD);
        @(posedge clk); #1;
        total++; if (pend_valid_o !== 1'b1) begin bad++; $display("FAIL rih_pend_set got=%b exp=1", pend_valid_o); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 btnc_i = 1'b0;
        #1;
        total++; if (rf_we_o !== 1'b0 || pend_valid_o !== 1'b0 || rf_waddr_o !== 5'd0) begin
            bad++; $display("FAIL rih_now got=%b/%b/%0d exp=0/0/0", rf_we_o, pend_valid_o, rf_waddr_o); end
        @(negedge clk);
        btnc_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (rf_we_o === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rih_no_write got=%0d exp=0", seen); end
    endtask

`ifdef WB_CONFLICT_STATS_EN
    task automatic test_stats();
        total++; if (conflict_cnt_o !== 16'd0) begin bad++; $display("FAIL stats_rst got=%0d exp=0", conflict_cnt_o); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
            @(posedge clk); #1;
            @(negedge clk);
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            @(posedge clk); #1;
        end
        total++; if (conflict_cnt_o !== 16'd3) begin bad++; $display("FAIL stats_cnt got=%0d exp=3", conflict_cnt_o); end
    endtask
`endif

    task automatic test_random();
        wr_t q[$];
        wr_t w[$];
        wr_t e;
        logic [4:0]  last_a, pend_a;
        logic [31:0] last_d, pend_d;
        logic rv, iv, hold, exp_stall, exp_we, exp_pv;
        logic [4:0] ra, ia;
        logic [31:0] rd, id;
        #1 btnc_i = 1'b0;
        @(negedge clk);
        btnc_i = 1'b1;
        last_a = '0; last_d = '0; pend_a = '0; pend_d = '0; hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rv = ($urandom_range(0, 3) != 0);
            iv = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rd = $urandom; id = $urandom;
            drive(rv, ra, rd, iv, ia, id);
            w.delete();
            if (!hold) begin
                if (rv && ra != 0 && iv && ia != 0 && ra == ia) begin
                    w.push_back('{a: ia, d: id});
                end else begin
                    if (rv && ra != 0) w.push_back('{a: ra, d: rd});
                    if (iv && ia != 0) w.push_back('{a: ia, d: id});
                end
            end
            exp_stall = (w.size() == 2);
            #1;
            total++; if (stall_o !== exp_stall) begin
                bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_o, exp_stall); end
            foreach (w[k]) q.push_back(w[k]);
            @(posedge clk); #1;
            exp_we = (q.size() > 0);
            if (exp_we) begin
                e = q.pop_front();
                last_a = e.a; last_d = e.d;
            end
            total++; if (rf_we_o !== exp_we || rf_waddr_o !== last_a || rf_wdata_o !== last_d) begin
                bad++; $display("FAIL rnd_rf n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n,
                                rf_we_o, rf_waddr_o, rf_wdata_o, exp_we, last_a, last_d); end
            exp_pv = (q.size() > 0);
            if (exp_pv) begin pend_a = q[0].a; pend_d = q[0].d; end
            hold = exp_pv;
            total++; if (pend_valid_o !== exp_pv || pend_addr_o !== pend_a || pend_data_o !== pend_d) begin
                bad++; $display("FAIL rnd_pend n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n,
                                pend_valid_o, pend_addr_o, pend_data_o, exp_pv, pend_a, pend_d); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_same_addr();
        test_reg0();
        test_back_to_back();
        test_reset_in_hold();
`ifdef WB_CONFLICT_STATS_EN
        test_stats();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 The module SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 The module SHALL have ports: btnc_i  in  1  reset, asynchronous, active-low.
REQ-003 The module SHALL have ports: wb_r_valid_i  in  1  lane R (older instruction of pair) requests register write.
REQ-004 The module SHALL have ports: wb_r_addr_i  in  5  lane R destination register.
REQ-005 The module SHALL have ports: wb_r_data_i  in  32  lane R write data.
REQ-006 The module SHALL have ports: wb_i_valid_i, wb_i_addr_i, wb_i_data_i  in  1/5/32  lane I (younger instruction) request, same meaning.
REQ-007 The module SHALL have ports: rf_we_o, rf_waddr_o, rf_wdata_o  out  1/5/32  single register-file write port, registered.
REQ-008 The module SHALL have ports: stall_o  out  1  combinational; freezes MEM/WB and all earlier stages for the current cycle.
REQ-009 The module SHALL have ports: pend_valid_o, pend_addr_o, pend_data_o  out  1/5/32  held lane I write, for forwarding.

Function
REQ-010 The block SHALL have states IDLE and HOLD; it SHALL leave reset in IDLE.
REQ-011 A lane SHALL be effective only when valid=1 and addr!=0; writes to register 0 SHALL be dropped silently.
REQ-012 In IDLE, with exactly one effective lane, that lane SHALL appear on the rf_* outputs at the next edge (latency 1); stall_o=0.
REQ-013 In IDLE, with both lanes effective and equal addresses, only lane I SHALL be written at the next edge, with stall_o=0 (younger wins).
REQ-014 In IDLE, with both lanes effective and different addresses (conflict), the block SHALL assert stall_o in the same cycle. At the next edge it SHALL write lane R, capture lane I into pend_*, set pend_valid_o=1 and move to HOLD.
REQ-015 In HOLD, the lane inputs SHALL be ignored (the upstream pair is frozen and already consumed). stall_o SHALL be 0. At the next edge the block SHALL write pend_*, clear pend_valid_o and return to IDLE.
REQ-016 In any cycle with no write issued, rf_we_o SHALL be 0 at the next edge. rf_waddr_o and rf_wdata_o SHALL hold their previous values.
REQ-017 stall_o SHALL never be high for two consecutive cycles; a back-to-back conflict SHALL produce the pattern stall 1,0,1,0.
REQ-018 pend_addr_o and pend_data_o SHALL hold their last captured values while pend_valid_o=0.

Reset
REQ-019 Asserting btnc_i=0 SHALL immediately force state=IDLE and all registered outputs (rf_*, pend_*) to 0; stall_o SHALL be 0 during reset.
REQ-020 Reset asserted while in HOLD SHALL discard the pending write; it SHALL never be issued.
REQ-021 Reset deassertion SHALL take effect at the first rising edge after btnc_i returns to 1.

Configuration
REQ-022 With macro WB_CONFLICT_STATS_EN defined, the block SHALL add output conflict_cnt_o (16 bits). The counter SHALL increment on each conflict edge per REQ-014, saturate at 0xFFFF and reset to 0.
REQ-023 Without WB_CONFLICT_STATS_EN, the port and counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-024 Single write: R valid, addr 5, data 0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234; stall_o=0 throughout.
REQ-025 Conflict: R(3,0xA), I(7,0xB) together -> stall_o=1 that cycle; cycle+1 writes (3,0xA) with pend_valid=1, pend_addr=7; cycle+2 writes (7,0xB) with pend_valid=0.
REQ-026 Same address: R(9,0x1), I(9,0x2) -> single write (9,0x2); stall_o=0; no HOLD.
REQ-027 Register 0: R(0,0xFF), I(4,0x5) -> only (4,0x5) written; no stall. R(0,..) alone -> rf_we stays 0.
REQ-028 Reset in HOLD: create conflict, pull btnc_i low mid-HOLD -> rf_we=0, pend_valid=0 at once; after release, no write to the pending register.
REQ-029 Stats (macro on): three conflicts -> conflict_cnt_o=3; preload 0xFFFF, then one conflict -> count stays 0xFFFF.
